log_antilog_pipe: RTL and testbench
===================================

# log_antilog_pipe

Pipelined antilogarithm stage of the Mitchell-style log multiplier. It sits directly after the log-domain adder, which supplies the summed characteristic and the biased summed mantissa. It converts that log-domain sum back to a binary product by mantissa reconstruction and barrel shift. A valid/ready handshake on both sides lets it sit between the operand front-end and any stalling consumer.

## Interface
- DWIDTH, 16, operand width (8 or 16); product is 2*DWIDTH bits
- M_WIDTH, 6, truncated mantissa fraction bits (t)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- in_zero  in  1  either original operand was zero; forces product 0
- sum_k  in  $clog2(DWIDTH)+1  k1+k2
- sum_x  in  M_WIDTH+1  x1_t+x2_t+1; MSB is mantissa carry
- out_valid  out  1  product present
- out_ready  in  1  consumer accepts product
- product  out  2*DWIDTH  approximate product

## Operation
- Transfer on either side occurs when valid && ready are both high at a rising edge.
- Decode: c = sum_x[M_WIDTH]; f = sum_x[M_WIDTH-1:0]; E = sum_k + c (width $clog2(DWIDTH)+1, no overflow since max E = 2*DWIDTH-1); M = {1'b1, f} (M_WIDTH+1 bits).
- product = (M << E) >> M_WIDTH, truncated toward zero. The shift is computed in 2*DWIDTH+M_WIDTH+1 bits; the result always fits in 2*DWIDTH bits.
- in_zero = 1 gives product = 0, regardless of sum_k and sum_x.
- Stage 1 (S1) registers E, M, zero and a valid bit. Stage 2 (S2) registers the shifted product and a valid bit; out_valid = S2 valid.
- Stall rule, per stage: advance = !next_valid || next_consumed. S2 is consumed when out_valid && out_ready. in_ready = !s1_valid || s2_can_load. This is combinational from out_ready; no skid buffer is used.
- Under backpressure, product and out_valid hold stable until consumed. Data is never dropped or duplicated.
- Simultaneous fill and drain in the same cycle is allowed at each stage, sustaining 1 beat/cycle.

## Timing
- Latency is 2 cycles. A beat accepted at edge n appears with out_valid = 1 after edge n+1 and is consumable at edge n+2 with no backpressure.
- Throughput is 1 product/cycle when out_ready is held high.
- Reset values: s1_valid = 0, s2_valid = 0, out_valid = 0, product = 0, in_ready = 1 (combinational from the valid bits).
- Reset asserted mid-operation flushes both stages immediately. Beats in flight are discarded. After deassertion the first edge may accept input.
- Inputs other than the valid/ready handshake signals are don't-care when in_valid = 0.

## Structure
- Shared package log_mult_pkg: DWIDTH and M_WIDTH defaults, derived widths KW = $clog2(DWIDTH)+1 and PW = 2*DWIDTH, and a packed typedef for the S1 payload (E, M, zero).
- One sub-module is natural: log_antilog_shift, a combinational barrel shift from (M, E, zero) to product. It is instantiated between S1 and the S2 register and can be reused by a future unpipelined variant.
- Pipeline control (valid bits, in_ready) lives in the top module.

## Test plan
- 3×5 (sum_k=3, sum_x=49, zero=0), out_ready=1 -> product=14 (0x0E) two edges after acceptance.
- 3×3 carry case (sum_k=2, sum_x=65) -> c=1, E=3, M=65, product=8.
- Maximum case (sum_k=30, sum_x=127) -> E=31, product=0xFE000000. Also present in_zero=1 with the same sum fields -> product=0.
- Back-to-back stream of 8 beats with out_ready low for cycles 3–6 -> in_ready drops after both stages fill, product held stable, all 8 outputs emerge in order with no loss or duplication.
- Assert rst while 2 beats are in flight -> out_valid=0 and product=0 immediately (asynchronously), neither beat emerges after release, and the next beat completes with 2-cycle latency.
- Random stimulus against a reference model of (({1,f}) << (sum_k+c)) >> M_WIDTH for DWIDTH=8/M_WIDTH=4 and DWIDTH=16/M_WIDTH=6, with random out_ready -> exact match, in order.

Source files
------------

// File: rtl/log_mult_pkg.sv
// Shared widths and payload types for the Mitchell log multiplier datapath.
package log_mult_pkg;

    localparam int unsigned DWIDTH_DEF  = 16;
    localparam int unsigned M_WIDTH_DEF = 6;

    // Characteristic-sum width and product width for a given operand width.
    function automatic int unsigned kw_for(input int unsigned dw);
        return $clog2(dw) + 1;
    endfunction

    function automatic int unsigned pw_for(input int unsigned dw);
        return 2 * dw;
    endfunction

    localparam int unsigned KW = kw_for(DWIDTH_DEF);
    localparam int unsigned PW = pw_for(DWIDTH_DEF);

    // Stage-1 payload at the default widths: shift amount, mantissa with
    // hidden one, and the zero-operand override.
    typedef struct packed {
        logic [KW-1:0]        e;
        logic [M_WIDTH_DEF:0] m;
        logic                 zero;
    } s1_payload_t;

endpackage

// File: rtl/log_antilog_shift.sv
// Combinational antilog: product = ({1,f} << E) >> M_WIDTH, or 0 on zero.
module log_antilog_shift
    import log_mult_pkg::*;
#(
    parameter int unsigned DWIDTH  = DWIDTH_DEF,
    parameter int unsigned M_WIDTH = M_WIDTH_DEF
) (
    input  logic [M_WIDTH:0]        mant,
    input  logic [$clog2(DWIDTH):0] exp_sh,
    input  logic                    zero,
    output logic [2*DWIDTH-1:0]     product_c
);

    localparam int unsigned PRW = pw_for(DWIDTH);
    // Wide enough that the largest mantissa shifted by the largest E never overflows.
    localparam int unsigned SW  = PRW + M_WIDTH + 1;

    // Barrel shift in the wide domain, then drop the fraction bits.
    always_comb begin
        product_c = '0;
        if (!zero) begin
            product_c = PRW'((SW'(mant) << exp_sh) >> M_WIDTH);
        end
    end

endmodule

// File: rtl/log_antilog_pipe.sv
// Two-stage antilog pipeline with valid/ready handshake on both sides.
module log_antilog_pipe
    import log_mult_pkg::*;
#(
    parameter int unsigned DWIDTH  = DWIDTH_DEF,
    parameter int unsigned M_WIDTH = M_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_zero,
    input  logic [$clog2(DWIDTH):0] sum_k,
    input  logic [M_WIDTH:0]        sum_x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DWIDTH-1:0]     product
);

    localparam int unsigned EW  = kw_for(DWIDTH);
    localparam int unsigned PRW = pw_for(DWIDTH);

    typedef struct packed {
        logic [EW-1:0]    e;
        logic [M_WIDTH:0] m;
        logic             zero;
    } s1_t;

    logic           s1_valid_q, s1_valid_d;
    s1_t            s1_q, s1_d;
    logic           s2_valid_q, s2_valid_d;
    logic [PRW-1:0] prod_q, prod_d;
    logic [PRW-1:0] shift_prod;
    logic           s2_can_load;

    // A stage may load when it is empty or its content leaves this cycle.
    assign s2_can_load = !s2_valid_q || out_ready;
    assign in_ready    = !s1_valid_q || s2_can_load;
    assign out_valid   = s2_valid_q;
    assign product     = prod_q;

    // Stage 1 next state: decode carry into the exponent, restore hidden one.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.e    = sum_k + EW'(sum_x[M_WIDTH]);
                s1_d.m    = {1'b1, sum_x[M_WIDTH-1:0]};
                s1_d.zero = in_zero;
            end
        end
    end

    log_antilog_shift #(
        .DWIDTH  (DWIDTH),
        .M_WIDTH (M_WIDTH)
    ) u_shift (
        .mant      (s1_q.m),
        .exp_sh    (s1_q.e),
        .zero      (s1_q.zero),
        .product_c (shift_prod)
    );

    // Stage 2 next state: capture the shifted product, hold under backpressure.
    always_comb begin
        s2_valid_d = s2_valid_q;
        prod_d     = prod_q;
        if (s2_can_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                prod_d = shift_prod;
            end
        end
    end

    // Pipeline registers; reset flushes both stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            prod_q     <= prod_d;
        end
    end

endmodule

// File: tb/tb_log_antilog_pipe.sv
// Directed and randomized checks of the antilog pipeline at two widths.
module tb_log_antilog_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DWIDTH=16 / M_WIDTH=6 instance
    logic        in_valid16, in_ready16, in_zero16, out_valid16, out_ready16;
    logic [4:0]  sum_k16;
    logic [6:0]  sum_x16;
    logic [31:0] product16;

    // DWIDTH=8 / M_WIDTH=4 instance
    logic        in_valid8, in_ready8, in_zero8, out_valid8, out_ready8;
    logic [3:0]  sum_k8;
    logic [4:0]  sum_x8;
    logic [15:0] product8;

    log_antilog_pipe #(.DWIDTH(16), .M_WIDTH(6)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_zero(in_zero16),
        .sum_k(sum_k16), .sum_x(sum_x16),
        .out_valid(out_valid16), .out_ready(out_ready16), .product(product16)
    );

    log_antilog_pipe #(.DWIDTH(8), .M_WIDTH(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_zero(in_zero8),
        .sum_k(sum_k8), .sum_x(sum_x8),
        .out_valid(out_valid8), .out_ready(out_ready8), .product(product8)
    );

    int checks = 0;
    int errors = 0;
    int n_out16 = 0;
    int sent;
    int base;

    logic [31:0] q16[$];
    logic [15:0] q8[$];
    logic [31:0] exp16, prev16, got16;
    logic [15:0] exp8, prev8, got8;
    logic hold16 = 1'b0, hold8 = 1'b0, saw_stall16 = 1'b0;
    logic fire_in16, fire_out16, fire_in8, fire_out8;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ref_prod(input int t, input logic z, input int k, input int x);
        logic [63:0] m;
        int c;
        c = (x >> t) & 1;
        m = 64'((1 << t) | (x & ((1 << t) - 1)));
        if (z) return 64'd0;
        return (m << (k + c)) >> t;
    endfunction

    // Called at a falling edge with inputs driven; samples, scores, advances one clock.
    task automatic cycle();
        #1;
        fire_in16  = in_valid16 && in_ready16;
        fire_out16 = out_valid16 && out_ready16;
        fire_in8   = in_valid8 && in_ready8;
        fire_out8  = out_valid8 && out_ready8;
        if (in_valid16 && !in_ready16) saw_stall16 = 1'b1;
        if (hold16) begin
            chk("hold_valid16", 64'(out_valid16), 64'd1);
            chk("hold_prod16", 64'(product16), 64'(prev16));
        end
        if (hold8) begin
            chk("hold_valid8", 64'(out_valid8), 64'd1);
            chk("hold_prod8", 64'(product8), 64'(prev8));
        end
        if (fire_in16) q16.push_back(exp16);
        if (fire_in8)  q8.push_back(exp8);
        if (fire_out16) begin
            if (q16.size() == 0) begin
                chk("spurious_out16", 64'(fire_out16), 64'd0);
            end else begin
                got16 = q16.pop_front();
                chk("prod16", 64'(product16), 64'(got16));
                n_out16++;
            end
        end
        if (fire_out8) begin
            if (q8.size() == 0) begin
                chk("spurious_out8", 64'(fire_out8), 64'd0);
            end else begin
                got8 = q8.pop_front();
                chk("prod8", 64'(product8), 64'(got8));
            end
        end
        hold16 = out_valid16 && !out_ready16;
        prev16 = product16;
        hold8  = out_valid8 && !out_ready8;
        prev8  = product8;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (q16.size() != 0 || q8.size() != 0); i++) cycle();
        chk("drain16", 64'(q16.size()), 64'd0);
        chk("drain8", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid16 = 1'b0; in_zero16 = 1'b0; sum_k16 = '0; sum_x16 = '0; out_ready16 = 1'b1;
        in_valid8  = 1'b0; in_zero8  = 1'b0; sum_k8  = '0; sum_x8  = '0; out_ready8  = 1'b1;
        exp16 = '0; exp8 = '0; prev16 = '0; prev8 = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_out_valid", 64'(out_valid16), 64'd0);
        chk("rst_product", 64'(product16), 64'd0);
        chk("rst_in_ready", 64'(in_ready16), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // 3x5 with latency checks
        in_valid16 = 1'b1; sum_k16 = 5'd3; sum_x16 = 7'd49; exp16 = 32'd14;
        cycle();
        in_valid16 = 1'b0;
        chk("lat_ov_s1", 64'(out_valid16), 64'd0);
        cycle();
        chk("lat_ov_s2", 64'(out_valid16), 64'd1);
        chk("p_3x5", 64'(product16), 64'd14);
        cycle();
        chk("lat_ov_done", 64'(out_valid16), 64'd0);

        // Carry, maximum and zero-override cases back to back
        in_valid16 = 1'b1; sum_k16 = 5'd2;  sum_x16 = 7'd65;  exp16 = 32'd8;
        cycle();
        sum_k16 = 5'd30; sum_x16 = 7'd127; exp16 = 32'hFE000000;
        cycle();
        in_zero16 = 1'b1; exp16 = 32'd0;
        cycle();
        in_valid16 = 1'b0; in_zero16 = 1'b0;
        drain();

        // 8-beat stream with backpressure on cycles 3..6
        saw_stall16 = 1'b0; base = n_out16; sent = 0;
        for (int i = 0; i < 40 && sent < 8; i++) begin
            in_valid16 = 1'b1; in_zero16 = 1'b0;
            sum_k16 = 5'(sent + 2); sum_x16 = 7'(sent * 9);
            exp16 = 32'(ref_prod(6, 1'b0, sent + 2, sent * 9));
            out_ready16 = !(i >= 3 && i <= 6);
            cycle();
            if (fire_in16) sent++;
        end
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        drain();
        chk("stream_sent", 64'(sent), 64'd8);
        chk("stream_out", 64'(n_out16 - base), 64'd8);
        chk("in_ready_drop", 64'(saw_stall16), 64'd1);

        // Reset with two beats in flight
        in_valid16 = 1'b1; sum_k16 = 5'd6; sum_x16 = 7'd10;
        exp16 = 32'(ref_prod(6, 1'b0, 6, 10));
        cycle();
        sum_k16 = 5'd7; exp16 = 32'(ref_prod(6, 1'b0, 7, 10));
        cycle();
        in_valid16 = 1'b0;
        chk("pre_rst_ov", 64'(out_valid16), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_ov", 64'(out_valid16), 64'd0);
        chk("async_rst_prod", 64'(product16), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready16), 64'd1);
        q16.delete(); q8.delete(); hold16 = 1'b0; hold8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle();
        in_valid16 = 1'b1; sum_k16 = 5'd4; sum_x16 = 7'd0; exp16 = 32'd16;
        cycle();
        in_valid16 = 1'b0;
        chk("post_rst_ov_s1", 64'(out_valid16), 64'd0);
        cycle();
        chk("post_rst_ov_s2", 64'(out_valid16), 64'd1);
        chk("post_rst_prod", 64'(product16), 64'd16);
        cycle();
        chk("post_rst_done", 64'(out_valid16), 64'd0);

        // Random traffic on both widths against the reference formula
        for (int i = 0; i < 400; i++) begin
            in_valid16  = 1'($urandom_range(0, 1));
            in_zero16   = ($urandom_range(0, 7) == 0);
            sum_k16     = 5'($urandom_range(0, 30));
            sum_x16     = 7'($urandom_range(0, 127));
            out_ready16 = ($urandom_range(0, 3) != 0);
            exp16 = 32'(ref_prod(6, in_zero16, int'(sum_k16), int'(sum_x16)));
            in_valid8   = 1'($urandom_range(0, 1));
            in_zero8    = ($urandom_range(0, 7) == 0);
            sum_k8      = 4'($urandom_range(0, 14));
            sum_x8      = 5'($urandom_range(0, 31));
            out_ready8  = ($urandom_range(0, 3) != 0);
            exp8 = 16'(ref_prod(4, in_zero8, int'(sum_k8), int'(sum_x8)));
            cycle();
        end
        in_valid16 = 1'b0; in_valid8 = 1'b0; out_ready16 = 1'b1; out_ready8 = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
